multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

- Moore-style control FSM for the multicycle RISC-V datapath.
- Sequences fetch, decode, execute, memory and write-back for R-type, I-type ALU, LW, SW and BEQ.
- Drives all datapath enables, mux selects and the 2-bit ALU-op class (00 add, 01 sub, 10 funct-decoded) that feeds the ALU control decoder.
- Sits between the instruction register/zero flag and the datapath; talks to unified memory through a req/ready handshake.

## Interface
Parameters:
- none; opcodes are fixed: R 7'b0110011, I-ALU 7'b0010011, LW 7'b0000011, SW 7'b0100011, BEQ 7'b1100011.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  7  IR[6:0]; must be stable from DECODE until the instruction completes.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  1 = write, 0 = read.
- iord  out  1  address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load IR from memory data.
- mdr_write  out  1  load MDR from memory data.
- pc_write  out  1  load PC.
- pc_src  out  1  PC source: 0 = ALU result, 1 = ALUOut.
- alu_src_a  out  2  ALU A select: 00 PC, 01 old PC, 10 rs1.
- alu_src_b  out  2  ALU B select: 00 rs2, 01 constant 4, 10 immediate.
- alu_op  out  2  ALU-op class to the ALU control decoder.
- alu_imm  out  1  datapath forces IR[30] to 0 into the ALU decoder (I-type).
- reg_write  out  1  register file write.
- mem_to_reg  out  1  write-back source: 0 = ALUOut, 1 = MDR.
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction.
- illegal  out  1  unsupported opcode seen; sticky until reset.

## Operation
- States: IDLE, FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, ILLEGAL.
- All outputs decode from the current state (plus mem_ready/zero where noted). Any output not listed for a state is 0.
- IDLE: all outputs 0. Next state is FETCH unconditionally.
- FETCH: mem_req=1, iord=0, alu_src_a=00, alu_src_b=01, alu_op=00.
  - ir_write=pc_write=mem_ready, pc_src=0.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: alu_src_a=01, alu_src_b=10, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - R → EXEC_R
  - I-ALU → EXEC_I
  - LW or SW → ADDR
  - BEQ → BRANCH
  - anything else → ILLEGAL
- EXEC_R: alu_src_a=10, alu_src_b=00, alu_op=10. Next: WB_ALU.
- EXEC_I: alu_src_a=10, alu_src_b=10, alu_op=10, alu_imm=1. Next: WB_ALU.
- ADDR: alu_src_a=10, alu_src_b=10, alu_op=00. Next: MEM_RD if opcode is LW, else MEM_WR.
- MEM_RD: mem_req=1, iord=1, mem_we=0, mdr_write=mem_ready. Stay until mem_ready=1, then WB_MEM.
- MEM_WR: mem_req=1, iord=1, mem_we=1, instr_done=mem_ready. Stay until mem_ready=1, then FETCH.
- WB_ALU: reg_write=1, mem_to_reg=0, instr_done=1. Next: FETCH.
- WB_MEM: reg_write=1, mem_to_reg=1, instr_done=1. Next: FETCH.
- BRANCH: alu_src_a=10, alu_src_b=00, alu_op=01, pc_src=1, pc_write=zero, instr_done=1. Next: FETCH.
- ILLEGAL: illegal=1, all other outputs 0. Absorbing; only reset leaves it.

## Timing
- Reset: rst_n low forces state to IDLE asynchronously; every output is 0 immediately and stays 0 while rst_n=0.
- First FETCH occurs in the second rising edge after rst_n deasserts.
- Cycles per instruction with zero-wait memory (mem_ready=1 on the first request cycle):
  - R or I-ALU: 4
  - LW: 5
  - SW: 4
  - BEQ: 3
- Each memory wait cycle adds 1.
- Handshake rules:
  - Once mem_req is asserted, it holds with iord and mem_we unchanged until the cycle mem_ready=1.
  - mem_ready is ignored outside FETCH, MEM_RD and MEM_WR.
- ir_write, mdr_write and pc_write in FETCH/MEM_RD assert only in the cycle mem_ready=1; never for more than one cycle per access.
- instr_done asserts exactly once per completed instruction, never in IDLE, FETCH, DECODE or ILLEGAL.
- Reset asserted mid-access: mem_req drops immediately. No write-enable (reg_write, pc_write, ir_write, mdr_write) may be observed high in the following cycle.

## Test plan
- Reset then R-type ADD, mem_ready tied 1:
  - State trace IDLE, FETCH, DECODE, EXEC_R, WB_ALU.
  - alu_op=10 in EXEC_R; reg_write=1 and instr_done=1 in cycle 4 after FETCH entry.
- LW with mem_ready delayed 3 cycles in both FETCH and MEM_RD:
  - mem_req held high with constant iord for 3 cycles each.
  - ir_write and mdr_write each pulse once.
  - WB_MEM has mem_to_reg=1; total 11 cycles.
- BEQ with zero=1, then BEQ with zero=0:
  - BRANCH has alu_op=01 and pc_src=1.
  - pc_write=1 for zero=1, pc_write=0 for zero=0; both take 3 cycles.
- ADDI (opcode 0010011): EXEC_I has alu_imm=1, alu_src_b=10, alu_op=10; SW then drives mem_we=1 with iord=1 in MEM_WR.
- Opcode 7'b1101111 in DECODE: ILLEGAL entered; illegal=1 persists 20 cycles with all other outputs 0; rst_n pulse clears to IDLE.
- rst_n asserted asynchronously mid-MEM_WR while mem_ready=0: mem_req and mem_we fall before the next clock edge; after release the trace restarts at IDLE then FETCH.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle RISC-V datapath.
// It steps each instruction through fetch, decode, execute, memory and write-back.
// The supported instructions are R-type, I-type ALU, LW, SW and BEQ.
// All outputs are decoded from the current state.
// A few outputs are also gated by mem_ready or zero.
// Because of this, asynchronous reset forces every output to 0 at once.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       mdr_write,
    output logic       pc_write,
    output logic       pc_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       alu_imm,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       instr_done,
    output logic       illegal
);

    localparam logic [6:0] OpR    = 7'b0110011;
    localparam logic [6:0] OpIAlu = 7'b0010011;
    localparam logic [6:0] OpLw   = 7'b0000011;
    localparam logic [6:0] OpSw   = 7'b0100011;
    localparam logic [6:0] OpBeq  = 7'b1100011;

    typedef enum logic [3:0] {
        StIdle,
        StFetch,
        StDecode,
        StExecR,
        StExecI,
        StAddr,
        StMemRd,
        StMemWr,
        StWbAlu,
        StWbMem,
        StBranch,
        StIllegal
    } state_e;

    state_e state_q, state_d;

    // State register; asynchronous reset returns to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; memory states wait on mem_ready, DECODE dispatches on opcode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   state_d = StFetch;
            StFetch:  if (mem_ready) state_d = StDecode;
            StDecode: begin
                unique case (opcode)
                    OpR:         state_d = StExecR;
                    OpIAlu:      state_d = StExecI;
                    OpLw, OpSw:  state_d = StAddr;
                    OpBeq:       state_d = StBranch;
                    default:     state_d = StIllegal;
                endcase
            end
            StExecR:  state_d = StWbAlu;
            StExecI:  state_d = StWbAlu;
            StAddr:   state_d = (opcode == OpLw) ? StMemRd : StMemWr;
            StMemRd:  if (mem_ready) state_d = StWbMem;
            StMemWr:  if (mem_ready) state_d = StFetch;
            StWbAlu:  state_d = StFetch;
            StWbMem:  state_d = StFetch;
            StBranch: state_d = StFetch;
            StIllegal: state_d = StIllegal;
            default:  state_d = StIdle;
        endcase
    end

    // Output decode; any output not named for a state stays 0.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        mdr_write  = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        alu_imm    = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        unique case (state_q)
            StFetch: begin
                // PC+4 is computed every fetch cycle.
                // It is only committed on the cycle the word arrives.
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            StDecode: begin
                // Speculative branch target into ALUOut (old PC + imm).
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
            end
            StExecR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            StExecI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b10;
                alu_op    = 2'b10;
                alu_imm   = 1'b1;
            end
            StAddr: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b10;
            end
            StMemRd: begin
                mem_req   = 1'b1;
                iord      = 1'b1;
                mdr_write = mem_ready;
            end
            StMemWr: begin
                mem_req    = 1'b1;
                iord       = 1'b1;
                mem_we     = 1'b1;
                instr_done = mem_ready;
            end
            StWbAlu: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            StWbMem: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            StBranch: begin
                alu_src_a  = 2'b10;
                alu_op     = 2'b01;
                pc_src     = 1'b1;
                pc_write   = zero;
                instr_done = 1'b1;
            end
            StIllegal: illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl.
// It compares the full output vector against hand-built expectations at each step.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, iord, ir_write, mdr_write, pc_write, pc_src;
    logic [1:0] alu_src_a, alu_src_b, alu_op;
    logic       alu_imm, reg_write, mem_to_reg, instr_done, illegal;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .iord       (iord),
        .ir_write   (ir_write),
        .mdr_write  (mdr_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .alu_imm    (alu_imm),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .instr_done (instr_done),
        .illegal    (illegal)
    );

    logic [17:0] obs;
    assign obs = {mem_req, mem_we, iord, ir_write, mdr_write, pc_write, pc_src,
                  alu_src_a, alu_src_b, alu_op, alu_imm, reg_write, mem_to_reg,
                  instr_done, illegal};

    // Field order: req we iord irw mdrw pcw pcsrc a b op imm rw m2r done ill
    function automatic logic [17:0] mk(input logic rq, input logic we, input logic io,
                                       input logic irw, input logic mdw, input logic pcw,
                                       input logic pcs, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] op,
                                       input logic imm, input logic rw, input logic m2r,
                                       input logic dn, input logic il);
        return {rq, we, io, irw, mdw, pcw, pcs, a, b, op, imm, rw, m2r, dn, il};
    endfunction

    task automatic chk_now(input string tag, input logic [17:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs are set just after a rising edge; check mid-cycle, then move to the next cycle.
    task automatic step(input string tag, input logic [17:0] exp);
        #3;
        chk_now(tag, exp);
        @(posedge clk);
        #1;
    endtask

    logic [17:0] e_zero, e_fetch_w, e_fetch_go, e_decode, e_exec_r, e_exec_i, e_addr;
    logic [17:0] e_memrd_w, e_memrd_go, e_memwr_w, e_memwr_go, e_wb_alu, e_wb_mem;
    logic [17:0] e_br_z1, e_br_z0, e_illegal;

    initial begin
        e_zero     = 18'd0;
        e_fetch_w  = mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 0, 0, 0, 0, 0);
        e_fetch_go = mk(1, 0, 0, 1, 0, 1, 0, 2'b00, 2'b01, 2'b00, 0, 0, 0, 0, 0);
        e_decode   = mk(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, 0, 0, 0, 0, 0);
        e_exec_r   = mk(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 0, 0, 0, 0, 0);
        e_exec_i   = mk(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b10, 2'b10, 1, 0, 0, 0, 0);
        e_addr     = mk(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b10, 2'b00, 0, 0, 0, 0, 0);
        e_memrd_w  = mk(1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        e_memrd_go = mk(1, 0, 1, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        e_memwr_w  = mk(1, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        e_memwr_go = mk(1, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 0);
        e_wb_alu   = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0, 1, 0);
        e_wb_mem   = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 1, 1, 0);
        e_br_z1    = mk(0, 0, 0, 0, 0, 1, 1, 2'b10, 2'b00, 2'b01, 0, 0, 0, 1, 0);
        e_br_z0    = mk(0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b01, 0, 0, 0, 1, 0);
        e_illegal  = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1);

        // Reset held: outputs zero even with mem_ready high.
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        step("reset_hold", e_zero);
        rst_n = 1'b1;

        // R-type ADD, zero-wait memory.
        opcode = 7'b0110011;
        step("r_idle", e_zero);
        step("r_fetch", e_fetch_go);
        step("r_decode", e_decode);
        step("r_exec", e_exec_r);
        step("r_wb", e_wb_alu);

        // LW with three wait cycles in FETCH and in MEM_RD: 11 cycles total.
        opcode = 7'b0000011;
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step("lw_fetch_wait", e_fetch_w);
        mem_ready = 1'b1;
        step("lw_fetch_go", e_fetch_go);
        mem_ready = 1'b0;
        step("lw_decode", e_decode);
        mem_ready = 1'b1;   // ignored in ADDR
        step("lw_addr", e_addr);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step("lw_memrd_wait", e_memrd_w);
        mem_ready = 1'b1;
        step("lw_memrd_go", e_memrd_go);
        step("lw_wb", e_wb_mem);

        // BEQ taken, then BEQ not taken.
        opcode = 7'b1100011;
        zero = 1'b1;
        step("beq1_fetch", e_fetch_go);
        step("beq1_decode", e_decode);
        step("beq1_branch", e_br_z1);
        zero = 1'b0;
        step("beq0_fetch", e_fetch_go);
        step("beq0_decode", e_decode);
        step("beq0_branch", e_br_z0);

        // ADDI.
        opcode = 7'b0010011;
        step("addi_fetch", e_fetch_go);
        step("addi_decode", e_decode);
        step("addi_exec", e_exec_i);
        step("addi_wb", e_wb_alu);

        // SW with one wait cycle in MEM_WR.
        opcode = 7'b0100011;
        step("sw_fetch", e_fetch_go);
        step("sw_decode", e_decode);
        mem_ready = 1'b0;
        step("sw_addr", e_addr);
        step("sw_memwr_wait", e_memwr_w);
        mem_ready = 1'b1;
        step("sw_memwr_go", e_memwr_go);

        // SW interrupted by asynchronous reset while waiting in MEM_WR.
        step("swr_fetch", e_fetch_go);
        step("swr_decode", e_decode);
        mem_ready = 1'b0;
        step("swr_addr", e_addr);
        #2;
        chk_now("swr_memwr_wait", e_memwr_w);
        rst_n = 1'b0;
        #1;
        chk_now("swr_async_reset", e_zero);
        @(posedge clk);
        #1;
        mem_ready = 1'b1;
        chk_now("swr_reset_after_edge", e_zero);
        rst_n = 1'b1;
        step("swr_idle", e_zero);
        step("swr_fetch_again", e_fetch_go);

        // Unsupported opcode: ILLEGAL absorbs, ignoring all inputs.
        opcode = 7'b1101111;
        step("ill_decode", e_decode);
        for (int i = 0; i < 20; i++) begin
            mem_ready = i[0];
            zero = i[1];
            step("ill_hold", e_illegal);
        end
        rst_n = 1'b0;
        #1;
        chk_now("ill_reset", e_zero);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mem_ready = 1'b1;
        step("ill_idle", e_zero);
        step("ill_fetch", e_fetch_go);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
